// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants and types for the shift unit arbiter
package shift_arb_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_PASS = 2'b11
   } shift_op_t;

   typedef logic req_id_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational 1/2/4/8/16 barrel shifter for SLL/SRL/SRA/pass
module shift_core
   import shift_arb_pkg::*;
#(
   parameter int DATA_W  = shift_arb_pkg::DATA_W,
   parameter int SHAMT_W = shift_arb_pkg::SHAMT_W
) (
   input  logic [DATA_W-1:0]  x,
   input  logic [SHAMT_W-1:0] amt,
   input  shift_op_t          op,
   output logic [DATA_W-1:0]  y
);

   logic [DATA_W-1:0] stage;

   // each amt bit enables one power-of-two stage; SRA replicates the sign per stage
   always_comb begin
      stage = x;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (amt[k]) begin
            case (op)
               OP_SLL:  stage = stage << (1 << k);
               OP_SRA:  stage = $signed(stage) >>> (1 << k);
               default: stage = stage >> (1 << k);
            endcase
         end
      end
      y = (op == OP_PASS) ? x : stage;
   end

endmodule

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin arbiter sharing one shifter; optional SHIFT_ARB_STATS_EN counters
module shift_unit_arbiter
   import shift_arb_pkg::*;
#(
   parameter int DATA_W  = shift_arb_pkg::DATA_W,
   parameter int SHAMT_W = shift_arb_pkg::SHAMT_W
`ifdef SHIFT_ARB_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_x,
   input  logic [SHAMT_W-1:0] req0_amt,
   input  logic [1:0]         req0_op,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_x,
   input  logic [SHAMT_W-1:0] req1_amt,
   input  logic [1:0]         req1_op,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output req_id_t            rsp_id
`ifdef SHIFT_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]   stat_grant0,
   output logic [CNT_W-1:0]   stat_grant1,
   output logic [CNT_W-1:0]   stat_conflict
`endif
);

   req_id_t            rr_ptr;
   req_id_t            gnt_id;
   logic               slot_free;
   logic               accept;
   logic [DATA_W-1:0]  sel_x;
   logic [SHAMT_W-1:0] sel_amt;
   logic [1:0]         sel_op;
   logic [DATA_W-1:0]  shift_y;

   assign slot_free = !rsp_valid || rsp_ready;
   assign accept    = slot_free && (req0_valid || req1_valid);

   // on contention the requester not served last wins
   always_comb begin
      gnt_id = 1'b0;
      if (req0_valid && req1_valid) gnt_id = ~rr_ptr;
      else if (req1_valid)          gnt_id = 1'b1;
   end

   assign req0_ready = accept && (gnt_id == 1'b0);
   assign req1_ready = accept && (gnt_id == 1'b1);

   assign sel_x   = gnt_id ? req1_x   : req0_x;
   assign sel_amt = gnt_id ? req1_amt : req0_amt;
   assign sel_op  = gnt_id ? req1_op  : req0_op;

   shift_core #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .x   (sel_x),
      .amt (sel_amt),
      .op  (shift_op_t'(sel_op)),
      .y   (shift_y)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         rr_ptr    <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= shift_y;
         rsp_id    <= gnt_id;
         rr_ptr    <= gnt_id;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef SHIFT_ARB_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_grant0   <= '0;
         stat_grant1   <= '0;
         stat_conflict <= '0;
      end else begin
         if (req0_ready && stat_grant0 != '1)
            stat_grant0 <= stat_grant0 + 1'b1;
         if (req1_ready && stat_grant1 != '1)
            stat_grant1 <= stat_grant1 + 1'b1;
         if (req0_valid && req1_valid && slot_free && stat_conflict != '1)
            stat_conflict <= stat_conflict + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;
   import shift_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_x, req1_x;
   logic [4:0]  req0_amt, req1_amt;
   logic [1:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   req_id_t     rsp_id;
`ifdef SHIFT_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1, stat_conflict;
   logic [1:0]  sat_grant0, sat_grant1, sat_conflict;
   logic        sat_req0_ready, sat_req1_ready, sat_rsp_valid;
   logic [31:0] sat_rsp_data;
   req_id_t     sat_rsp_id;
`endif

   always #5 clock = ~clock;

   shift_unit_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_amt   (req0_amt),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_amt   (req1_amt),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
      ,
      .stat_grant0   (stat_grant0),
      .stat_grant1   (stat_grant1),
      .stat_conflict (stat_conflict)
`endif
   );

`ifdef SHIFT_ARB_STATS_EN
   shift_unit_arbiter #(.CNT_W(2)) dut_sat (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (sat_req0_ready),
      .req0_x     (req0_x),
      .req0_amt   (req0_amt),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (sat_req1_ready),
      .req1_x     (req1_x),
      .req1_amt   (req1_amt),
      .req1_op    (req1_op),
      .rsp_valid  (sat_rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (sat_rsp_data),
      .rsp_id     (sat_rsp_id),
      .stat_grant0   (sat_grant0),
      .stat_grant1   (sat_grant1),
      .stat_conflict (sat_conflict)
   );
`endif

   typedef struct {
      logic        v;
      logic [31:0] x;
      logic [4:0]  amt;
      logic [1:0]  op;
   } req_t;

   typedef struct {
      logic        id;
      logic [31:0] x;
      logic [4:0]  amt;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   int errors = 0;
   int checks = 0;

   req_t        p [2];
   logic        m_valid, m_id, last_id;
   logic [31:0] m_data;
   vec_t        vt [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // shifts expressed as multiply / floor-divide by powers of two
   function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] amt, input logic [1:0] op);
      logic [63:0] d, w;
      d = 64'd1 << amt;
      case (op)
         2'b00:   begin w = {32'd0, x} * d; return w[31:0]; end
         2'b01:   begin w = {32'd0, x} / d; return w[31:0]; end
         2'b10:   begin
                     w = {32'd0, (x[31] ? ~x : x)} / d;
                     return x[31] ? ~w[31:0] : w[31:0];
                  end
         default: return x;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_id = 1'b0; last_id = 1'b0;
      p[0].v = 1'b0; p[1].v = 1'b0;
   endtask

   task automatic set_req(input int r, input logic [31:0] x, input logic [4:0] amt, input logic [1:0] op);
      p[r].v = 1'b1; p[r].x = x; p[r].amt = amt; p[r].op = op;
   endtask

   // entered and left at posedge+1: checks registered outputs, drives, checks readies, advances model
   task automatic step(input logic rr);
      logic free, any, gid;
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_data", rsp_data, m_data);
      check("rsp_id", rsp_id, m_id);
      req0_valid = p[0].v; req0_x = p[0].x; req0_amt = p[0].amt; req0_op = p[0].op;
      req1_valid = p[1].v; req1_x = p[1].x; req1_amt = p[1].amt; req1_op = p[1].op;
      rsp_ready  = rr;
      #1;
      free = !m_valid || rr;
      any  = free && (p[0].v || p[1].v);
      gid  = (p[0].v && p[1].v) ? (last_id == 1'b0) : p[1].v;
      check("req0_ready", req0_ready, any && !gid);
      check("req1_ready", req1_ready, any && gid);
      if (any) begin
         m_data  = ref_shift(p[gid].x, p[gid].amt, p[gid].op);
         m_id    = gid;
         m_valid = 1'b1;
         last_id = gid;
         p[gid].v = 1'b0;
      end else if (m_valid && rr) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("reset_valid", rsp_valid, 0);
      check("reset_data", rsp_data, 0);
      check("reset_id", rsp_id, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      vt[0] = '{1'b0, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
      vt[1] = '{1'b0, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
      vt[2] = '{1'b1, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678};
      vt[3] = '{1'b1, 32'h1234_5678, 5'd16, 2'b00, 32'h5678_0000};
      vt[4] = '{1'b1, 32'h1234_5678, 5'd9,  2'b11, 32'h1234_5678};
      vt[5] = '{1'b0, 32'h1234_5678, 5'd4,  2'b01, 32'h0123_4567};
      vt[6] = '{1'b1, 32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000};
      vt[7] = '{1'b0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
      vt[8] = '{1'b1, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
      vt[9] = '{1'b0, 32'hFFFF_FFFF, 5'd1,  2'b01, 32'h7FFF_FFFF};

      for (int r = 0; r < 2; r++) begin
         p[r].v = 1'b0; p[r].x = '0; p[r].amt = '0; p[r].op = '0;
      end
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_x = '0; req1_x = '0; req0_amt = '0; req1_amt = '0; req0_op = '0; req1_op = '0;
      reset = 1'b1;
      @(posedge clock);
      do_reset();

      // reset mid-stall, then rr_ptr back at 0
      set_req(0, 32'h0000_0001, 5'd4, 2'b00);
      step(1'b1);
      step(1'b0);
      check("stall_data", rsp_data, 32'h0000_0010);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_valid", rsp_valid, 0);
      check("async_reset_data", rsp_data, 0);
      model_reset();
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      set_req(0, 32'h0000_00F0, 5'd4, 2'b01);
      set_req(1, 32'h0000_000F, 5'd4, 2'b00);
      step(1'b1);
      check("first_grant_after_reset", rsp_id, 1);
      step(1'b1);
      check("second_grant_after_reset", rsp_id, 0);

      // table-driven single ops, each accepted on an idle slot
      for (int i = 0; i < 10; i++) begin
         set_req(int'(vt[i].id), vt[i].x, vt[i].amt, vt[i].op);
         step(1'b1);
         check("vec_valid", rsp_valid, 1);
         check("vec_data", rsp_data, vt[i].exp);
         check("vec_id", rsp_id, vt[i].id);
      end

      // dual contention, one result per cycle
      for (int i = 0; i < 6; i++) begin
         for (int r = 0; r < 2; r++)
            if (!p[r].v) set_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         step(1'b1);
         check("contend_valid", rsp_valid, 1);
         check("contend_id", rsp_id, (i % 2 == 0) ? 1 : 0);
      end

      // backpressure with both requesters waiting
      for (int r = 0; r < 2; r++)
         if (!p[r].v) set_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 3; i++) step(1'b0);
      step(1'b1);
      check("after_backpressure_id", rsp_id, 1);
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      step(1'b1);
      step(1'b1);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < 2; r++)
            if (!p[r].v && $urandom_range(0, 1) == 1)
               set_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         step($urandom_range(0, 3) != 0);
      end
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      step(1'b1);

`ifdef SHIFT_ARB_STATS_EN
      do_reset();
      check("stat_reset_g0", 32'(stat_grant0), 0);
      for (int i = 0; i < 5; i++) begin
         set_req(0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         step(1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++)
            if (!p[r].v) set_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         step(1'b1);
      end
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      step(1'b1);
      check("stat_grant0", 32'(stat_grant0), 7);
      check("stat_grant1", 32'(stat_grant1), 2);
      check("stat_conflict", 32'(stat_conflict), 4);
      check("sat_grant0", 32'(sat_grant0), 3);
      check("sat_grant1", 32'(sat_grant1), 2);
      check("sat_conflict", 32'(sat_conflict), 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
Shares one 32-bit barrel-shift datapath (SLL/SRL/SRA) between two requesters: requester 0 is the processor ALU/execute path, requester 1 is the sprite/graphics engine.
- Round-robin arbitration with valid/ready handshakes on both request ports.
- One registered result stage with backpressure on a single shared response port.
- Sits beside the ALU; the shift datapath lives only in this block.

Parameters:
DATA_W, 32, operand/result width; fixed by the shift datapath (5-stage 1/2/4/8/16 mux network).
SHAMT_W, 5, shift amount width (log2 DATA_W).
CNT_W, 16, statistics counter width (used only with SHIFT_ARB_STATS_EN).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
req0_x  in  DATA_W  operand.
req0_amt  in  SHAMT_W  shift amount.
req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through.
req1_valid/req1_ready/req1_x/req1_amt/req1_op  same as requester 0.
rsp_valid  out  1  result register holds a valid result.
rsp_ready  in  1  consumer takes result when rsp_valid&rsp_ready.
rsp_data  out  DATA_W  shifted result.
rsp_id  out  1  requester that owns rsp_data.

Behaviour:
- Reset: one clock, port "clock"; reset is asynchronous and active-high, port "reset". Asserting reset immediately clears rsp_valid=0, rsp_data=0, rsp_id=0 and rr_ptr=0, with no clock edge required. A result in flight is discarded. Behaviour is normal from the first rising edge after deassertion.
- Stage free: slot_free = !rsp_valid | rsp_ready.
- Grant (combinational): when slot_free=0, both req_ready=0.
  - Only one valid: grant it.
  - Both valid: grant requester (rr_ptr ? 0 : 1), where rr_ptr = last granted id.
  - Only the granted requester sees req_ready=1. req_ready never depends on the other requester's ready.
- Accept at edge: rsp_data <= shift(x, amt, op) of the granted request; rsp_id <= grant id; rsp_valid <= 1; rr_ptr <= grant id.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 op/cycle while rsp_ready=1.
- Drain without new accept: when rsp_valid&rsp_ready and no request is granted, rsp_valid <= 0. rsp_data and rsp_id hold their values.
- Stall: when rsp_valid&!rsp_ready, rsp_data and rsp_id stay stable and both req_ready=0.
- Shift arithmetic:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with x[31].
  - amt=0 returns x.
  - amt=31 is the maximum; no wrap-around.
  - op 11 returns x unchanged regardless of amt.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1… A requester waits at most 1 grant slot.
- Protocol: a requester holds valid/x/amt/op stable until accepted. Inputs are sampled only on the accept edge.

Optional Feature:
SHIFT_ARB_STATS_EN: adds outputs stat_grant0, stat_grant1 and stat_conflict, each CNT_W bits.
- stat_grant0 / stat_grant1 increment on each accept for that requester.
- stat_conflict increments on each cycle where both req_valid=1 and slot_free=1.
- Counters saturate at all-ones and clear on reset.
- Without the macro: these ports and registers do not exist; functionality is otherwise identical.

Decomposition:
- Package shift_arb_pkg holds: op encodings (OP_SLL, OP_SRL, OP_SRA, OP_PASS), DATA_W/SHAMT_W constants, and the requester id type.
- One sub-module, shift_core: a combinational 5-stage mux network implementing SLL/SRL/SRA from the op, instantiated once.
- Arbitration, result register and counters stay in the top module.

Test Plan:
- Reset mid-stall: accept req0 {x=0x0000_0001, amt=4, SLL}, hold rsp_ready=0, assert reset between edges -> rsp_valid=0 immediately; after release rr_ptr=0, so simultaneous requests grant requester 1 first.
- Single-op latency: req0 {0x8000_0000, amt=31, SRA} accepted at edge N -> at N+1 rsp_valid=1, rsp_data=0xFFFF_FFFF, rsp_id=0. The same operand with SRL -> 0x0000_0001.
- Dual contention, rsp_ready=1 for 6 cycles: both valid continuously -> rsp_id sequence 1,0,1,0,1,0, one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> req0_ready=req1_ready=0 throughout and rsp_data stable. On rsp_ready=1, the next grant is the requester not last served.
- Boundary ops: req1 {0x1234_5678, amt=0, SLL} -> 0x1234_5678; {0x1234_5678, amt=16, SLL} -> 0x5678_0000; op=11, amt=9 -> 0x1234_5678.
- With SHIFT_ARB_STATS_EN: 5 req0-only ops plus 4 cycles of dual contention -> stat_grant0=7, stat_grant1=2, stat_conflict=4. Force near-saturation with CNT_W=2 -> counter holds at 3.
